// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HDR  = 3'd1,
    LOAD = 3'd2,
    DONE = 3'd3,
    ERR  = 3'd4
  } loader_state_t;

  localparam int HDR_BYTES = 4;
  localparam int PACK_W    = HDR_BYTES * 8;
  localparam int CNT_W     = $clog2(HDR_BYTES);

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Little-endian byte assembler: o_valid flags the byte that completes a word,
// with o_word presenting the full word in that same cycle.
module byte_packer
  import imem_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_clr,
  input  logic              i_en,
  input  logic [7:0]        i_byte,
  output logic              o_valid,
  output logic [PACK_W-1:0] o_word
);

  // Only the three most recent bytes are kept; the fourth arrives on i_byte.
  logic [PACK_W-9:0] r_word;
  logic [CNT_W-1:0]  r_cnt;

  assign o_word  = {i_byte, r_word};
  assign o_valid = i_en && (r_cnt == CNT_W'(HDR_BYTES - 1));

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_word <= '0;
      r_cnt  <= '0;
    end else if (i_en) begin
      r_word <= o_word[PACK_W-1:8];
      r_cnt  <= o_valid ? '0 : r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Streams a length-prefixed byte program into instruction memory and holds
// the CPU fetch path in reset until the final word has been written.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int                     ADDRESS_WIDTH = 32,
  parameter int                     DATA_WIDTH    = 32,
  parameter int                     MEM_WORDS     = 256,
  parameter logic [ADDRESS_WIDTH-1:0] BASE_ADDR   = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [7:0]               byte_data,
  input  logic                     byte_valid,
  output logic                     byte_ready,
  output logic                     mem_we,
  output logic [ADDRESS_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]    mem_wdata,
  output logic                     cpu_rst,
  output logic                     done,
  output logic                     error
);

  loader_state_t         r_state, w_next;
  logic [DATA_WIDTH-1:0] r_nwords, r_idx, w_hdr;
  logic                  r_cpu_rst;
  logic                  w_xfer, w_clr, w_word_valid;
  logic [PACK_W-1:0]     w_word;

  assign w_xfer  = byte_valid && byte_ready;
  assign w_hdr   = DATA_WIDTH'(w_word);
  assign done    = (r_state == DONE);
  assign error   = (r_state == ERR);
  assign cpu_rst = r_cpu_rst;

  byte_packer u_pack (
    .clk     (clk),
    .rst     (rst),
    .i_clr   (w_clr),
    .i_en    (w_xfer),
    .i_byte  (byte_data),
    .o_valid (w_word_valid),
    .o_word  (w_word)
  );

  always_comb begin
    w_next     = r_state;
    byte_ready = 1'b0;
    w_clr      = 1'b0;
    case (r_state)
      IDLE, DONE, ERR: begin
        if (start) begin
          w_next = HDR;
          w_clr  = 1'b1;
        end
      end
      HDR: begin
        byte_ready = 1'b1;
        if (w_word_valid) begin
          if (w_hdr == '0)                          w_next = DONE;
          else if (w_hdr > DATA_WIDTH'(MEM_WORDS))  w_next = ERR;
          else                                      w_next = LOAD;
        end
      end
      LOAD: begin
        byte_ready = 1'b1;
        // Leave LOAD on the edge that launches the last write.
        if (w_word_valid && (r_idx == r_nwords - 1'b1)) w_next = DONE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_nwords  <= '0;
      r_idx     <= '0;
      r_cpu_rst <= 1'b1;
      mem_we    <= 1'b0;
      mem_addr  <= BASE_ADDR;
      mem_wdata <= '0;
    end else begin
      r_state   <= w_next;
      r_cpu_rst <= (r_state != DONE);
      mem_we    <= 1'b0;
      if ((r_state == HDR) && w_word_valid) begin
        r_nwords <= w_hdr;
        r_idx    <= '0;
      end
      if ((r_state == LOAD) && w_word_valid) begin
        mem_we    <= 1'b1;
        mem_wdata <= DATA_WIDTH'(w_word);
        mem_addr  <= BASE_ADDR + ADDRESS_WIDTH'({r_idx, 2'b00});
        r_idx     <= r_idx + 1'b1;
      end
    end
  end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter ADDRESS_WIDTH, default 32: width of mem_addr, byte address.
REQ-002 Parameter DATA_WIDTH, default 32: width of mem_wdata and the word-count header.
REQ-003 Parameter MEM_WORDS, default 256: instruction memory capacity in words.
REQ-004 Parameter BASE_ADDR, default 32'h0: byte address of the first loaded word, equal to the PC reset value.
REQ-005 clk  input  1  sole clock; all state updates on rising edge.
REQ-006 rst  input  1  reset; synchronous, active-high.
REQ-007 start  input  1  one-cycle request to begin a load.
REQ-008 byte_data  input  8  incoming program byte.
REQ-009 byte_valid  input  1  byte_data is valid.
REQ-010 byte_ready  output  1  loader accepts a byte this cycle.
REQ-011 mem_we  output  1  instruction-memory write strobe.
REQ-012 mem_addr  output  ADDRESS_WIDTH  write byte address.
REQ-013 mem_wdata  output  DATA_WIDTH  assembled instruction word.
REQ-014 cpu_rst  output  1  holds the fetch path (PC register) in reset while high.
REQ-015 done  output  1  program fully loaded.
REQ-016 error  output  1  header word count exceeds MEM_WORDS.

Function
REQ-017 The loader SHALL implement FSM states IDLE, HDR, LOAD, DONE, ERR.
REQ-018 A byte SHALL transfer only on a cycle with byte_valid and byte_ready both high; byte_ready SHALL be high only in HDR and LOAD.
REQ-019 IDLE: start -> HDR, byte counter cleared.
REQ-020 HDR SHALL accept 4 bytes little-endian (first byte -> bits 7:0) forming word count N.
REQ-021 After the 4th header byte: N == 0 -> DONE; N > MEM_WORDS -> ERR; else -> LOAD with word index 0.
REQ-022 LOAD SHALL assemble each 4 bytes little-endian into a word; the cycle after the 4th byte is accepted, mem_we SHALL be high for exactly one cycle with mem_wdata = word and mem_addr = BASE_ADDR + 4*index.
REQ-023 Word index SHALL increment after each write; after write N-1 the FSM SHALL be in DONE in the same cycle as that mem_we pulse.
REQ-024 mem_addr and mem_wdata SHALL hold their last values when mem_we is low.
REQ-025 done SHALL be high exactly while in DONE; error SHALL be high exactly while in ERR.
REQ-026 cpu_rst SHALL be a register equal to (state != DONE) delayed one cycle, so the last write completes before the CPU leaves reset.
REQ-027 start SHALL be ignored in HDR and LOAD; start in DONE or ERR SHALL enter HDR, reasserting cpu_rst the following cycle.
REQ-028 byte_valid with byte_ready low SHALL not be consumed; the source holds data until acceptance, and gaps of any length between bytes SHALL be tolerated.

Reset
REQ-029 rst SHALL, on the next rising edge from any state including mid-word, force IDLE, clear the byte and word counters, the partial word, and the header.
REQ-030 Reset values: byte_ready=0, mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0, cpu_rst=1, done=0, error=0.

Structure
REQ-031 A shared package SHALL hold the FSM state enum (loader_state_t) and the header byte count constant (HDR_BYTES=4).
REQ-032 One sub-module, byte_packer (4-byte little-endian shift/assemble with word_valid pulse), SHALL be used for both header and data assembly.

Verification
REQ-033 N=2, bytes 13 00 50 00 | 93 00 A0 00 (header 02 00 00 00 first) -> writes 0x00500013 @0x0, 0x00A00093 @0x4; done=1; cpu_rst low one cycle later.
REQ-034 Header 00 00 00 00 -> DONE directly, no mem_we pulse, error=0.
REQ-035 Header 01 01 00 00 (N=257, MEM_WORDS=256) -> ERR, error=1, byte_ready=0, cpu_rst stays 1; then start -> HDR.
REQ-036 byte_valid toggled randomly with 0-5 idle cycles between bytes, N=3 -> identical writes and addresses 0x0, 0x4, 0x8.
REQ-037 rst asserted after 2 bytes of word 1 of N=4 -> all outputs at reset values next cycle; fresh load then writes from BASE_ADDR correctly.
REQ-038 start asserted during LOAD -> ignored; start in DONE -> cpu_rst high next cycle and new load overwrites from BASE_ADDR.
